// File: rtl/miss_arbiter.sv
// Round-robin arbiter sharing one next-level memory port between the I-cache and D-cache miss paths.
// Optional statistics counters are built only when MISS_ARB_STATS_EN is defined.
module miss_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  output logic              d_done,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [31:0]       i_grants,
  output logic [31:0]       d_grants,
  output logic [31:0]       timeouts
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;        // 1 = D-cache held the most recent grant
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic                err_q, err_d;
  logic                grant_i, grant_d, timeout_evt;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    timeout_evt = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie the port that did not win last time goes first.
        grant_i = i_req && (!d_req || last_q);
        grant_d = d_req && !grant_i;
        if (grant_i || grant_d) begin
          state_d    = S_BUSY;
          last_d     = grant_d;
          wait_cnt_d = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = grant_d ? d_addr : i_addr;
          mem_we_d   = grant_d & d_we;
        end
      end
      S_BUSY: begin
        if (mem_ready || (wait_cnt_q == CNT_LAST)) begin
          state_d     = S_DONE;
          mem_req_d   = 1'b0;
          i_done_d    = !last_q;
          d_done_d    = last_q;
          err_d       = !mem_ready;
          timeout_evt = !mem_ready;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      wait_cnt_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      i_done_q   <= i_done_d;
      d_done_q   <= d_done_d;
      err_q      <= err_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign i_done   = i_done_q;
  assign d_done   = d_done_q;
  assign err      = err_q;

`ifdef MISS_ARB_STATS_EN
  logic [31:0] i_grants_q, i_grants_d;
  logic [31:0] d_grants_q, d_grants_d;
  logic [31:0] timeouts_q, timeouts_d;

  always_comb begin
    i_grants_d = i_grants_q + (grant_i     ? 32'd1 : 32'd0);
    d_grants_d = d_grants_q + (grant_d     ? 32'd1 : 32'd0);
    timeouts_d = timeouts_q + (timeout_evt ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_grants_q <= '0;
      d_grants_q <= '0;
      timeouts_q <= '0;
    end else begin
      i_grants_q <= i_grants_d;
      d_grants_q <= d_grants_d;
      timeouts_q <= timeouts_d;
    end
  end

  assign i_grants = i_grants_q;
  assign d_grants = d_grants_q;
  assign timeouts = timeouts_q;
`else
  logic unused_stats;
  assign unused_stats = grant_i ^ grant_d ^ timeout_evt;
  assign i_grants = '0;
  assign d_grants = '0;
  assign timeouts = '0;
`endif

endmodule

// File: tb/tb_miss_arbiter.sv
// Bench for miss_arbiter: directed scenarios followed by random request/ready traffic,
// checked against a transaction-level model of the arbitration and timeout rules.
module tb_miss_arbiter;

  localparam int ADDR_W = 26;
  localparam int TO     = 4;
`ifdef MISS_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_done;
  logic              d_req = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic              d_we = 1'b0;
  logic              d_done;
  logic              err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_ready = 1'b0;
  logic [31:0]       i_grants, d_grants, timeouts;

  miss_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_done(d_done),
    .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_ready(mem_ready),
    .i_grants(i_grants), .d_grants(d_grants), .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: who was granted last (1 = D) and expected statistics.
  bit          last_d = 1'b1;
  logic [31:0] m_ig = 0, m_dg = 0, m_to = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
    chk("i_grants", i_grants, STATS ? m_ig : 32'd0);
    chk("d_grants", d_grants, STATS ? m_dg : 32'd0);
    chk("timeouts", timeouts, STATS ? m_to : 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_i_done"},  {31'd0, i_done},  32'd0);
    chk({tag, "_d_done"},  {31'd0, d_done},  32'd0);
    chk({tag, "_err"},     {31'd0, err},     32'd0);
  endtask

  task automatic model_reset();
    last_d = 1'b1;
    m_ig = 0;
    m_dg = 0;
    m_to = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    model_reset();
    chk_quiet("reset");
    chk("reset_mem_addr", {6'd0, mem_addr}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk_stats();
    rst_n = 1'b1;
  endtask

  // Starts in an IDLE cycle with at least one request visible; ends in the following IDLE cycle.
  // delay = number of BUSY cycles before mem_ready; delay >= TO means no ready at all.
  task automatic do_txn(input int delay, input string tag);
    bit                win_d;
    bit                timed_out;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_we;
    win_d     = (i_req && d_req) ? !last_d : d_req;
    exp_addr  = win_d ? d_addr : i_addr;
    exp_we    = win_d ? d_we : 1'b0;
    timed_out = (delay >= TO);
    last_d    = win_d;
    if (win_d) m_dg++; else m_ig++;
    mem_ready = 1'($urandom_range(0, 1));
    tick();
    for (int b = 0; b < TO; b++) begin
      chk({tag, "_busy_mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, "_busy_mem_addr"}, {6'd0, mem_addr}, {6'd0, exp_addr});
      chk({tag, "_busy_mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
      chk({tag, "_busy_dones"}, {30'd0, i_done, d_done}, 32'd0);
      chk({tag, "_busy_err"}, {31'd0, err}, 32'd0);
      chk_stats();
      mem_ready = (b == delay);
      tick();
      if (b == delay) break;
    end
    if (timed_out) m_to++;
    chk({tag, "_done_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_done_i_done"}, {31'd0, i_done}, {31'd0, !win_d});
    chk({tag, "_done_d_done"}, {31'd0, d_done}, {31'd0, win_d});
    chk({tag, "_done_err"}, {31'd0, err}, {31'd0, timed_out});
    chk_stats();
    $display("txn %s: port=%s addr=%0h we=%0b delay=%0d err=%0b", tag, win_d ? "D" : "I",
             exp_addr, exp_we, delay, timed_out);
    if (win_d) d_req = 1'b0; else i_req = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    tick();
    chk_quiet({tag, "_idle"});
  endtask

  task automatic raise_i();
    i_addr = ADDR_W'($urandom());
    i_req  = 1'b1;
  endtask

  task automatic raise_d();
    d_addr = ADDR_W'($urandom());
    d_we   = 1'($urandom_range(0, 1));
    d_req  = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    do_reset();

    // Single I request, immediate ready
    i_addr = 26'h0ABCDEF;
    i_req  = 1'b1;
    do_txn(0, "single_i");

    // Both from reset: I first, then D, then I again
    do_reset();
    i_addr = 26'h1; d_addr = 26'h2; d_we = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    do_txn(0, "tie_first");
    do_txn(0, "tie_second");
    i_req = 1'b1; d_req = 1'b1;
    do_txn(0, "tie_again");
    chk("tie_i_grants", i_grants, STATS ? 32'd2 : 32'd0);
    chk("tie_d_grants", d_grants, STATS ? 32'd1 : 32'd0);
    do_txn(0, "tie_drain");

    // Continuous requests on both ports
    for (int n = 0; n < 10; n++) begin
      if (!i_req) raise_i();
      if (!d_req) raise_d();
      do_txn($urandom_range(0, 2), "continuous");
    end
    do_txn(0, "continuous_drain");

    // Timeout, then ready in the final BUSY cycle
    raise_i();
    do_txn(TO, "timeout");
    raise_d();
    do_txn(TO - 1, "late_ready");

    // Reset while BUSY aborts; held request is re-granted afterwards
    raise_i();
    mem_ready = 1'b0;
    tick();
    chk("abort_busy_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    model_reset();
    chk_quiet("abort");
    chk_stats();
    rst_n = 1'b1;
    do_txn(1, "regrant");

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      if (!i_req && !d_req && $urandom_range(0, 3) == 0) begin
        mem_ready = 1'($urandom_range(0, 1));
        tick();
        chk_quiet("gap");
        chk_stats();
      end
      if (!i_req && $urandom_range(0, 1) == 1) raise_i();
      if (!d_req && $urandom_range(0, 1) == 1) raise_d();
      if (!i_req && !d_req) raise_i();
      do_txn($urandom_range(0, TO), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
